// File: rtl/rv_pkg.sv
// Shared pipeline types for the RV core: memory-op control bundle, writeback
// select, LSU FSM states and the alignment check used by the load/store unit.
package rv_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } t_mem_size;

  typedef enum logic [1:0] {
    SEL_WB_ALU  = 2'd0,
    SEL_WB_PC4  = 2'd1,
    SEL_WB_DMEM = 2'd2
  } t_sel_wb;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } t_lsu_state;

  typedef struct packed {
    logic      valid_Q103H;
    logic      mem_rd_Q103H;
    logic      mem_wr_Q103H;
    t_mem_size mem_size_Q103H;
    logic      mem_sign_ext_Q103H;
    t_sel_wb   sel_wb_Q103H;
  } t_mem_ctrl;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input t_mem_size size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      HALF:    mis = off[0];
      WORD:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dff_macros.svh
// Flop macros shared across the core: enable flop with async active-low clear,
// and enable flop with async active-low reset to an explicit value.
`ifndef DFF_MACROS_SVH
`define DFF_MACROS_SVH

`define DFF_EN(q, d, en, clk, rst_n) \
  always_ff @(posedge clk or negedge rst_n) begin \
    if (!rst_n) q <= '0; \
    else if (en) q <= d; \
  end

`define DFF_RST_N_EN(q, d, en, clk, rst_n, rv) \
  always_ff @(posedge clk or negedge rst_n) begin \
    if (!rst_n) q <= rv; \
    else if (en) q <= d; \
  end

`endif

// File: rtl/rv_lsu_align.sv
// Byte-lane logic for the LSU: store byte enables and lane replication, plus
// load-lane extraction with optional sign extension.
module rv_lsu_align
  import rv_pkg::*;
(
  input  t_mem_size   size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for both directions, keyed by access size.
  always_comb begin
    be      = 4'b0000;
    wdata   = 32'h0000_0000;
    ld_data = 32'h0000_0000;
    byte_s  = rdata[{off, 3'b000} +: 8];
    half_s  = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      BYTE: begin
        be      = 4'b0001 << off;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sign_ext & byte_s[7]}}, byte_s};
      end
      HALF: begin
        be      = 4'b0011 << off;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sign_ext & half_s[15]}}, half_s};
      end
      WORD: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
      end
      default: begin
        be      = 4'b0000;
        wdata   = 32'h0000_0000;
        ld_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Q103H load/store unit: issues data-memory requests, stalls while one is
// outstanding, and produces the Q103H forwarding and Q104H writeback values.
`include "dff_macros.svh"

module rv_lsu
  import rv_pkg::*;
#(
  parameter bit STORE_WAIT_RSP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  t_mem_ctrl   ctrl,
  input  logic [31:0] alu_out_Q103H,
  input  logic [31:0] dmem_wr_data_Q103H,
  input  logic [31:0] pc_plus4_Q103H,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data_Q103H,
  output logic [31:0] wb_data_Q104H,
  output logic        lsu_stall_Q103H,
  output logic        misalign_Q103H
);

  t_lsu_state  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_q104_q, wb_q104_d;

  logic        mem_op_s, aligned_op_s, latch_en_s, complete_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, ld_data_s;

  rv_lsu_align u_align (
    .size     (ctrl.mem_size_Q103H),
    .off      (alu_out_Q103H[1:0]),
    .sign_ext (ctrl.mem_sign_ext_Q103H),
    .st_data  (dmem_wr_data_Q103H),
    .rdata    (dmem_rdata),
    .be       (be_s),
    .wdata    (wdata_s),
    .ld_data  (ld_data_s)
  );

  assign mem_op_s       = ctrl.valid_Q103H & (ctrl.mem_rd_Q103H | ctrl.mem_wr_Q103H);
  assign misalign_Q103H = mem_op_s & is_misaligned(ctrl.mem_size_Q103H, alu_out_Q103H[1:0]);
  assign aligned_op_s   = mem_op_s & ~misalign_Q103H;
  assign latch_en_s     = (state_q == IDLE) & aligned_op_s & ~dmem_gnt;
  assign addr_d         = {alu_out_Q103H[31:2], 2'b00};
  assign we_d           = ctrl.mem_wr_Q103H;
  assign be_d           = be_s;
  assign wdata_d        = wdata_s;

  // State register and request latches for an ungranted first request.
  `DFF_RST_N_EN(state_q, state_d, 1'b1, clk, rst, IDLE)
  `DFF_RST_N_EN(addr_q, addr_d, latch_en_s, clk, rst, 32'h0000_0000)
  `DFF_RST_N_EN(we_q, we_d, latch_en_s, clk, rst, 1'b0)
  `DFF_RST_N_EN(be_q, be_d, latch_en_s, clk, rst, 4'b0000)
  `DFF_RST_N_EN(wdata_q, wdata_d, latch_en_s, clk, rst, 32'h0000_0000)

  // Next-state: a granted store without response wait finishes immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!aligned_op_s)                                 state_d = IDLE;
        else if (!dmem_gnt)                                state_d = REQ;
        else if (ctrl.mem_wr_Q103H && !STORE_WAIT_RSP)     state_d = IDLE;
        else                                               state_d = RSP;
      end
      REQ: begin
        if (!dmem_gnt)                                     state_d = REQ;
        else if (we_q && !STORE_WAIT_RSP)                  state_d = IDLE;
        else                                               state_d = RSP;
      end
      RSP: begin
        if (dmem_rvalid) state_d = IDLE;
        else             state_d = RSP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request outputs and completion; IDLE drives the live Q103H fields.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = we_q;
    dmem_addr  = addr_q;
    dmem_be    = be_q;
    dmem_wdata = wdata_q;
    complete_s = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req   = aligned_op_s & rst;
        dmem_we    = ctrl.mem_wr_Q103H;
        dmem_addr  = addr_d;
        dmem_be    = be_s;
        dmem_wdata = wdata_s;
        complete_s = aligned_op_s & dmem_gnt & ctrl.mem_wr_Q103H & !STORE_WAIT_RSP;
      end
      REQ: begin
        dmem_req   = rst;
        complete_s = dmem_gnt & we_q & !STORE_WAIT_RSP;
      end
      RSP: begin
        dmem_req   = 1'b0;
        complete_s = dmem_rvalid;
      end
      default: begin
        dmem_req   = 1'b0;
        complete_s = 1'b0;
      end
    endcase
  end

  assign lsu_stall_Q103H = aligned_op_s & ~complete_s;

  // Forwarding value never carries load data; the stall covers load-use.
  always_comb begin
    if (ctrl.sel_wb_Q103H == SEL_WB_PC4) wb_data_Q103H = pc_plus4_Q103H;
    else                                 wb_data_Q103H = alu_out_Q103H;
  end

  always_comb begin
    if (misalign_Q103H)                                      wb_q104_d = 32'h0000_0000;
    else if (mem_op_s && ctrl.sel_wb_Q103H == SEL_WB_DMEM)   wb_q104_d = ld_data_s;
    else                                                     wb_q104_d = wb_data_Q103H;
  end

  // Q104H writeback register advances whenever the stage is not stalled.
  `DFF_EN(wb_q104_q, wb_q104_d, !lsu_stall_Q103H, clk, rst)

  assign wb_data_Q104H = wb_q104_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Randomized self-checking bench for rv_lsu against an arithmetic reference
// model of lane selection, extension, stall count and writeback value.
module tb_rv_lsu;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  t_mem_ctrl   ctrl;
  logic [31:0] alu_out, wr_data, pc4;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] wb_q103, wb_q104;
  logic        stall, misalign;

  int checks   = 0;
  int failures = 0;

  rv_lsu #(.STORE_WAIT_RSP(1'b0)) dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl               (ctrl),
    .alu_out_Q103H      (alu_out),
    .dmem_wr_data_Q103H (wr_data),
    .pc_plus4_Q103H     (pc4),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_be            (dmem_be),
    .dmem_wdata         (dmem_wdata),
    .dmem_gnt           (dmem_gnt),
    .dmem_rvalid        (dmem_rvalid),
    .dmem_rdata         (dmem_rdata),
    .wb_data_Q103H      (wb_q103),
    .wb_data_Q104H      (wb_q104),
    .lsu_stall_Q103H    (stall),
    .misalign_Q103H     (misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_be(input int sz, input int off);
    if (sz == 0) return 32'(1 << off);
    if (sz == 1) return 32'(3 << off);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input int off, input logic [31:0] rd, input bit sx);
    logic [31:0] v;
    if (sz == 0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // kind: 0 ALU op, 1 link (PC4), 2 load, 3 store. Called at posedge+1.
  task automatic run_op(input int kind, input int sz, input bit sx, input logic [31:0] addr,
                        input logic [31:0] d, input logic [31:0] pc, input logic [31:0] rdat,
                        input int gd, input int rdl);
    bit          is_mem, ld, mis;
    int          off, nstall;
    logic [31:0] exp_q103, exp_q104, exp_wd;
    is_mem   = (kind >= 2);
    ld       = (kind == 2);
    off      = int'(addr[1:0]);
    mis      = is_mem && ((sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0));
    exp_q103 = (kind == 1) ? pc : addr;
    exp_wd   = m_wdata(sz, d);
    if (mis)     exp_q104 = 32'h0;
    else if (ld) exp_q104 = m_load(sz, off, rdat, sx);
    else         exp_q104 = exp_q103;
    ctrl.valid_Q103H        = 1'b1;
    ctrl.mem_rd_Q103H       = ld;
    ctrl.mem_wr_Q103H       = (kind == 3);
    ctrl.mem_size_Q103H     = t_mem_size'(sz);
    ctrl.mem_sign_ext_Q103H = sx;
    ctrl.sel_wb_Q103H       = (kind == 1) ? SEL_WB_PC4 : (ld ? SEL_WB_DMEM : SEL_WB_ALU);
    alu_out = addr; wr_data = d; pc4 = pc;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    nstall = 0;
    if (!is_mem || mis) begin
      @(negedge clk);
      check_eq("q103_nomem", wb_q103, exp_q103);
      check_eq("misalign", 32'(misalign), 32'(mis));
      check_eq("req_nomem", 32'(dmem_req), 32'h0);
      check_eq("stall_nomem", 32'(stall), 32'h0);
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i <= gd; i++) begin
        if (i > 0) wr_data = $urandom;
        dmem_gnt = (i == gd);
        @(negedge clk);
        check_eq("req", 32'(dmem_req), 32'h1);
        check_eq("we", 32'(dmem_we), 32'(kind == 3));
        check_eq("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check_eq("be", 32'(dmem_be), m_be(sz, off));
        if (kind == 3) check_eq("wdata", dmem_wdata, exp_wd);
        check_eq("stall_req", 32'(stall), 32'(!(kind == 3 && i == gd)));
        check_eq("q103_mem", wb_q103, exp_q103);
        if (stall) nstall++;
        @(posedge clk); #1;
      end
      dmem_gnt = 1'b0;
      if (ld) begin
        for (int j = 1; j <= rdl; j++) begin
          dmem_rvalid = (j == rdl);
          dmem_rdata  = (j == rdl) ? rdat : $urandom;
          @(negedge clk);
          check_eq("req_rsp", 32'(dmem_req), 32'h0);
          check_eq("stall_rsp", 32'(stall), 32'(j != rdl));
          if (stall) nstall++;
          @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
      end
      check_eq("stall_cnt", 32'(nstall), 32'(gd + (ld ? rdl : 0)));
    end
    check_eq("q104", wb_q104, exp_q104);
  endtask

  initial begin
    rst = 1'b0;
    ctrl = '0;
    alu_out = 32'h0; wr_data = 32'h0; pc4 = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #12;
    check_eq("rst_req", 32'(dmem_req), 32'h0);
    check_eq("rst_q104", wb_q104, 32'h0);
    check_eq("rst_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(3, 2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1);
    run_op(3, 0, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 32'h0, 3, 1);
    run_op(2, 0, 1'b1, 32'h102, 32'h0, 32'h0, 32'h0080_0000, 0, 2);
    check_eq("lb_sext", wb_q104, 32'hFFFF_FF80);
    run_op(2, 0, 1'b0, 32'h102, 32'h0, 32'h0, 32'h0080_0000, 0, 2);
    check_eq("lbu", wb_q104, 32'h0000_0080);
    run_op(2, 2, 1'b0, 32'h102, 32'h0, 32'h0, 32'h1234_5678, 0, 1);
    check_eq("lw_misalign", wb_q104, 32'h0);
    run_op(1, 0, 1'b0, 32'h5555, 32'h0, 32'h2004, 32'h0, 0, 1);
    check_eq("jal_link", wb_q104, 32'h2004);

    for (int n = 0; n < 60; n++) begin
      int          kind, sz, gd, rdl;
      logic [31:0] addr;
      kind = $urandom_range(0, 3);
      sz   = $urandom_range(0, 2);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) addr[0] = 1'b0;
        if (sz == 2) addr[1:0] = 2'b00;
      end
      gd  = $urandom_range(0, 3);
      rdl = $urandom_range(1, 3);
      run_op(kind, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom, $urandom, gd, rdl);
    end

    // Reset pulse while a load waits for its response.
    ctrl = '0;
    ctrl.valid_Q103H    = 1'b1;
    ctrl.mem_rd_Q103H   = 1'b1;
    ctrl.mem_size_Q103H = WORD;
    ctrl.sel_wb_Q103H   = SEL_WB_DMEM;
    alu_out  = 32'h200;
    dmem_gnt = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_req", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check_eq("rsp_stall", 32'(stall), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("async_rst_req", 32'(dmem_req), 32'h0);
    check_eq("async_rst_q104", wb_q104, 32'h0);
    ctrl = '0;
    alu_out = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("stale_req", 32'(dmem_req), 32'h0);
    check_eq("stale_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check_eq("stale_q104", wb_q104, 32'h0);

    run_op(2, 1, 1'b1, 32'h306, 32'h0, 32'h0, 32'h8001_0000, 1, 1);
    check_eq("lh_after_rst", wb_q104, 32'hFFFF_8001);

    ctrl = '0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
# rv_lsu

Load/store unit for the Q103H (memory) stage. It receives the address, store data and return PC from the execute stage and drives the data-memory request/grant/response interface. It generates byte enables and store-lane replication, and aligns and sign-extends load data. It produces the writeback value for stage Q104H and the two forwarding values consumed by the execute stage, `wb_data_Q103H` and `wb_data_Q104H`. It stalls the pipeline while a memory transaction is outstanding.

## Interface
Parameters:
- `STORE_WAIT_RSP`, default 0: 0 means a store completes on grant; 1 means a store also waits for `dmem_rvalid`.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-low reset
- `ctrl`  in  `t_mem_ctrl`  fields: `valid_Q103H`, `mem_rd_Q103H`, `mem_wr_Q103H`, `mem_size_Q103H` (`t_mem_size`), `mem_sign_ext_Q103H`, `sel_wb_Q103H` (`t_sel_wb`)
- `alu_out_Q103H`  in  32  effective address, or ALU result for non-memory instructions
- `dmem_wr_data_Q103H`  in  32  store data, already forwarded
- `pc_plus4_Q103H`  in  32  link value
- `dmem_req`  out  1  request valid
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word address, bits [1:0] always 0
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_rvalid`  in  1  response valid
- `dmem_rdata`  in  32  read word
- `wb_data_Q103H`  out  32  forwarding value (combinational)
- `wb_data_Q104H`  out  32  registered writeback value
- `lsu_stall_Q103H`  out  1  freeze Q103H and all earlier stages
- `misalign_Q103H`  out  1  misaligned access detected (combinational)

## Operation
- Memory op: `valid_Q103H & (mem_rd_Q103H | mem_wr_Q103H)`.
- Misaligned:
  - HALF with `addr[0]=1`.
  - WORD with `addr[1:0]!=0`.
  - Effect: `misalign_Q103H=1`, no request issued, no stall, Q104H result is 0.
- Store lanes, with `off = addr[1:0]`:
  - BYTE: `be=4'b0001<<off`, `wdata={4{d[7:0]}}`.
  - HALF: `be=4'b0011<<off`, `wdata={2{d[15:0]}}`.
  - WORD: `be=4'b1111`, `wdata=d`.
  - Loads drive `be` by the same rule.
- Load extract:
  - BYTE: `rdata[8*off+:8]`.
  - HALF: `rdata[16*off[1]+:16]`.
  - WORD: `rdata`.
  - Zero-extend, or sign-extend when `mem_sign_ext_Q103H=1`.
- `wb_data_Q103H`:
  - `pc_plus4_Q103H` if `sel_wb=SEL_WB_PC4`.
  - Otherwise `alu_out_Q103H`.
  - Load data is never forwarded from Q103H. The load-use hazard is resolved by the stall.
- FSM states: IDLE, REQ, RSP.
  - IDLE, aligned memory op present: drive `dmem_req=1` combinationally from the `ctrl`/Q103H inputs.
    - `gnt=1`, store, `STORE_WAIT_RSP=0`: complete, stay in IDLE.
    - `gnt=1`, load, or store with `STORE_WAIT_RSP=1`: go to RSP.
    - `gnt=0`: latch addr/we/be/wdata, go to REQ.
  - REQ: hold `dmem_req=1` with latched fields unchanged until `gnt`. On `gnt`, go to RSP or IDLE by the same rule as IDLE.
  - RSP: `dmem_req=0`. On `dmem_rvalid`, capture the extracted load data, complete, go to IDLE.
  - `rvalid` arriving in the same cycle as `gnt` is not permitted. The responder guarantees at least one cycle of latency.
- `lsu_stall_Q103H = mem_op & ~misalign & ~complete_this_cycle`.
  - A completing cycle is the `gnt` cycle for a fire-and-forget store, or the `rvalid` cycle otherwise.
  - Stall is combinational from state and inputs.
- Q104H register: enabled when `~lsu_stall_Q103H`. It loads:
  - the load data if `sel_wb=SEL_WB_DMEM`;
  - 0 if misaligned;
  - else `wb_data_Q103H`.
- Bubbles (`valid_Q103H=0`) load `wb_data_Q103H` unchanged. Downstream qualifies by its own valid/`reg_write_en`.

## Timing
- Reset (async, `rst=0`):
  - FSM to IDLE.
  - `dmem_req=0`, `wb_data_Q104H=0`, latched request fields 0.
  - Takes effect immediately, including mid-transaction. Any outstanding response after reset is ignored (RSP has been left).
- Store with immediate grant: 0 stall cycles.
- Load with immediate grant and `rvalid` 1 cycle later: 1 stall cycle. The result appears on `wb_data_Q104H` the cycle after `rvalid`.
- Each cycle of `gnt` delay or `rvalid` delay adds one stall cycle.
- Request fields are stable from the first `req` cycle through `gnt`.
- Back-to-back memory ops: the next op's `req` may assert in the cycle after completion.

## Structure
- Add to `rv_pkg`:
  - `t_mem_size` (BYTE, HALF, WORD)
  - `t_sel_wb` (SEL_WB_ALU, SEL_WB_PC4, SEL_WB_DMEM)
  - `t_mem_ctrl`
  - `t_lsu_state`
- Use `DFF_EN` from `dff_macros.svh` for Q104H.
- The FSM and request latches need an async active-low flop variant. Add `DFF_RST_N_EN` to `dff_macros.svh`.
- One sub-module: `rv_lsu_align`, purely combinational. It takes size, offset and sign, and produces be, wdata and extracted load data.

## Test plan
- SW x=0xDEADBEEF to 0x100, `gnt` same cycle -> `req=1, we=1, be=1111, wdata=0xDEADBEEF`, no stall.
- SB 0xA5 to 0x103 -> `be=1000`, `wdata=0xA5A5A5A5`. Hold `gnt` low for 3 cycles -> 3 stall cycles, fields stable.
- LB from 0x102, `rdata=0x0080_0000`, `sign_ext=1`, `rvalid` 2 cycles after `gnt` -> `wb_data_Q104H=0xFFFFFF80`, 2 stall cycles. Repeat with LBU -> `0x00000080`.
- LW from 0x102 -> `misalign_Q103H=1`, `req=0`, no stall, `wb_data_Q104H=0`.
- Async `rst` pulse while in RSP -> `req=0` immediately, IDLE. A stale `rvalid` afterwards does not change `wb_data_Q104H`.
- JAL link, `sel_wb=SEL_WB_PC4`, `pc_plus4=0x2004` -> `wb_data_Q103H=0x2004` same cycle, `wb_data_Q104H=0x2004` the next cycle.
